// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, RGB565 colours and phase decode
package vga_pkg;

    localparam int VGA800_H_ACTIVE = 800;
    localparam int VGA800_H_FP     = 40;
    localparam int VGA800_H_SYNC   = 128;
    localparam int VGA800_H_BP     = 88;
    localparam int VGA800_V_ACTIVE = 600;
    localparam int VGA800_V_FP     = 1;
    localparam int VGA800_V_SYNC   = 4;
    localparam int VGA800_V_BP     = 23;
    localparam bit VGA800_SYNC_POL = 1'b1;

    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;
    localparam bit VGA640_SYNC_POL = 1'b0;

    localparam logic [15:0] RGB565_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB565_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB565_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB565_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB565_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB565_RED     = 16'hF800;
    localparam logic [15:0] RGB565_BLUE    = 16'h001F;
    localparam logic [15:0] RGB565_BLACK   = 16'h0000;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FP,
        PH_SYNC,
        PH_BP
    } vga_phase_e;

    function automatic vga_phase_e phase_of(input int pos, input int active,
                                            input int fp, input int sync);
        if (pos < active) begin
            return PH_ACTIVE;
        end else if (pos < active + fp) begin
            return PH_FP;
        end else if (pos < active + fp + sync) begin
            return PH_SYNC;
        end
        return PH_BP;
    endfunction

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB565_WHITE;
            3'd1:    return RGB565_YELLOW;
            3'd2:    return RGB565_CYAN;
            3'd3:    return RGB565_GREEN;
            3'd4:    return RGB565_MAGENTA;
            3'd5:    return RGB565_RED;
            3'd6:    return RGB565_BLUE;
            default: return RGB565_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_color_bar.sv
// rtl/vga_color_bar.sv - 8-bar colour pattern source, registered, 1-cycle latency
module vga_color_bar
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA800_H_ACTIVE,
    parameter int RGB_W    = 16
) (
    input  logic                        clk_in,
    input  logic                        rst,
    input  logic                        pix_req,
    input  logic [$clog2(H_ACTIVE)-1:0] pix_x,
    output logic [RGB_W-1:0]            rgb
);

    logic [31:0]      x_ext;
    logic [2:0]       bar_idx;
    logic [RGB_W-1:0] rgb_d;
    logic [RGB_W-1:0] rgb_q;

    always_comb begin
        x_ext   = 32'(pix_x);
        bar_idx = 3'((x_ext * 32'd8) / 32'(H_ACTIVE));
        rgb_d   = pix_req ? RGB_W'(bar_color(bar_idx)) : '0;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb = rgb_q;

endmodule

// File: rtl/vga_sync_module.sv
// rtl/vga_sync_module.sv - VGA raster timing and aligned pixel output stage
// Optional VGA_SYNC_TEST_PATTERN_EN replaces rgb_in with the internal colour bar.
module vga_sync_module
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA800_H_ACTIVE,
    parameter int H_FP     = VGA800_H_FP,
    parameter int H_SYNC   = VGA800_H_SYNC,
    parameter int H_BP     = VGA800_H_BP,
    parameter int V_ACTIVE = VGA800_V_ACTIVE,
    parameter int V_FP     = VGA800_V_FP,
    parameter int V_SYNC   = VGA800_V_SYNC,
    parameter int V_BP     = VGA800_V_BP,
    parameter bit SYNC_POL = VGA800_SYNC_POL,
    parameter int RGB_W    = 16
) (
    input  logic                        clk_in,
    input  logic                        rst,
    output logic                        pix_req,
    output logic [$clog2(H_ACTIVE)-1:0] pix_x,
    output logic [$clog2(V_ACTIVE)-1:0] pix_y,
    input  logic [RGB_W-1:0]            rgb_in,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        de,
    output logic [RGB_W-1:0]            rgb_out,
    output logic                        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int XW      = $clog2(H_ACTIVE);
    localparam int YW      = $clog2(V_ACTIVE);

    logic [HW-1:0]    h_d, h_q;
    logic [VW-1:0]    v_d, v_q;
    logic             pix_req_d, pix_req_q;
    logic [XW-1:0]    pix_x_d, pix_x_q;
    logic [YW-1:0]    pix_y_d, pix_y_q;
    logic             hs0_d, hs0_q, vs0_d, vs0_q, fs0_d, fs0_q;
    logic             de1_q, hs1_q, vs1_q, fs1_q;
    logic             hsync_d, hsync_q, vsync_d, vsync_q;
    logic             de_q, frame_start_q;
    logic [RGB_W-1:0] rgb_out_d, rgb_out_q;
    logic [RGB_W-1:0] src_rgb;

`ifdef VGA_SYNC_TEST_PATTERN_EN
    logic unused_rgb_in;
    assign unused_rgb_in = ^rgb_in;

    vga_color_bar #(
        .H_ACTIVE (H_ACTIVE),
        .RGB_W    (RGB_W)
    ) u_color_bar (
        .clk_in  (clk_in),
        .rst     (rst),
        .pix_req (pix_req_q),
        .pix_x   (pix_x_q),
        .rgb     (src_rgb)
    );
`else
    assign src_rgb = rgb_in;
`endif

    // h/v point at the position that the next edge presents on the request port
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (h_q == HW'(H_TOTAL - 1)) begin
            h_d = '0;
            if (v_q == VW'(V_TOTAL - 1)) begin
                v_d = '0;
            end else begin
                v_d = v_q + 1'b1;
            end
        end else begin
            h_d = h_q + 1'b1;
        end

        pix_req_d = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
        pix_x_d   = pix_req_d ? h_q[XW-1:0] : '0;
        pix_y_d   = pix_req_d ? v_q[YW-1:0] : '0;
        hs0_d     = phase_of(int'(h_q), H_ACTIVE, H_FP, H_SYNC) == PH_SYNC;
        vs0_d     = phase_of(int'(v_q), V_ACTIVE, V_FP, V_SYNC) == PH_SYNC;
        fs0_d     = (h_q == '0) && (v_q == '0);

        hsync_d   = hs1_q ? SYNC_POL : !SYNC_POL;
        vsync_d   = vs1_q ? SYNC_POL : !SYNC_POL;
        rgb_out_d = de1_q ? src_rgb : '0;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            h_q           <= '0;
            v_q           <= '0;
            pix_req_q     <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            hs0_q         <= 1'b0;
            vs0_q         <= 1'b0;
            fs0_q         <= 1'b0;
            de1_q         <= 1'b0;
            hs1_q         <= 1'b0;
            vs1_q         <= 1'b0;
            fs1_q         <= 1'b0;
            hsync_q       <= !SYNC_POL;
            vsync_q       <= !SYNC_POL;
            de_q          <= 1'b0;
            rgb_out_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            pix_req_q     <= pix_req_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            hs0_q         <= hs0_d;
            vs0_q         <= vs0_d;
            fs0_q         <= fs0_d;
            de1_q         <= pix_req_q;
            hs1_q         <= hs0_q;
            vs1_q         <= vs0_q;
            fs1_q         <= fs0_q;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de1_q;
            rgb_out_q     <= rgb_out_d;
            frame_start_q <= fs1_q;
        end
    end

    assign pix_req     = pix_req_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign rgb_out     = rgb_out_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_module.sv
// tb/tb_vga_sync_module.sv - directed bench on a reduced raster (32x12 totals)
module tb_vga_sync_module;

    localparam int HA = 20, HF = 3, HS = 5, HB = 4;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
`ifdef VGA_SYNC_TEST_PATTERN_EN
    localparam logic [15:0] EXP_FIRST = 16'hFFFF;
    localparam logic [15:0] EXP_LAST  = 16'h0000;
    localparam logic [15:0] EXP_MID   = 16'h07E0;
`else
    localparam logic [15:0] EXP_FIRST = 16'd0;
    localparam logic [15:0] EXP_LAST  = 16'd19;
    localparam logic [15:0] EXP_MID   = 16'd8;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        force_ff = 1'b0;
    logic        pix_req;
    logic [4:0]  pix_x;
    logic [2:0]  pix_y;
    logic [15:0] rgb_in;
    logic [15:0] src_q = 16'd0;
    logic        hsync, vsync, de, frame_start;
    logic [15:0] rgb_out;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) src_q <= 16'(pix_x);
    assign rgb_in = force_ff ? 16'hFFFF : src_q;

    vga_sync_module #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b1), .RGB_W (16)
    ) dut (
        .clk_in      (clk),
        .rst         (rst),
        .pix_req     (pix_req),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .rgb_in      (rgb_in),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .rgb_out     (rgb_out),
        .frame_start (frame_start)
    );

    task automatic test_reset;
        rst = 1'b1;
        repeat (10) @(negedge clk);
        tests++; if (pix_req !== 1'b0) begin fails++; $display("FAIL reset_pix_req got %0b exp 0", pix_req); end
        tests++; if (pix_x !== 5'd0) begin fails++; $display("FAIL reset_pix_x got %0d exp 0", pix_x); end
        tests++; if (pix_y !== 3'd0) begin fails++; $display("FAIL reset_pix_y got %0d exp 0", pix_y); end
        tests++; if (de !== 1'b0) begin fails++; $display("FAIL reset_de got %0b exp 0", de); end
        tests++; if (rgb_out !== 16'd0) begin fails++; $display("FAIL reset_rgb got %h exp 0000", rgb_out); end
        tests++; if (hsync !== 1'b0) begin fails++; $display("FAIL reset_hsync got %0b exp 0", hsync); end
        tests++; if (vsync !== 1'b0) begin fails++; $display("FAIL reset_vsync got %0b exp 0", vsync); end
        tests++; if (frame_start !== 1'b0) begin fails++; $display("FAIL reset_fs got %0b exp 0", frame_start); end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (pix_req !== 1'b1) begin fails++; $display("FAIL first_req got %0b exp 1", pix_req); end
        tests++; if (pix_x !== 5'd0 || pix_y !== 3'd0) begin fails++; $display("FAIL first_xy got (%0d,%0d) exp (0,0)", pix_x, pix_y); end
    endtask

    task automatic test_free_run;
        int last_hs = -1, hs_rise = -1, last_de_rise = -1, vs_rise = -1, last_fs = -1;
        int de_run = 0, de_frame = 0, nfs = 0;
        bit prev_hs = 1'b0, prev_de = 1'b0, prev_vs = 1'b0, saw_vs = 1'b0, de_line = 1'b0;
        repeat (2 * FRAME + 64) begin
            @(negedge clk);
            if (hsync && !prev_hs) begin
                if (last_hs >= 0) begin
                    tests++; if (cyc - last_hs != HT) begin fails++; $display("FAIL hsync_period got %0d exp %0d", cyc - last_hs, HT); end
                end
                if (de_line) begin
                    tests++; if (cyc - last_de_rise != HA + HF) begin fails++; $display("FAIL hsync_offset got %0d exp %0d", cyc - last_de_rise, HA + HF); end
                end
                last_hs = cyc; hs_rise = cyc; de_line = 1'b0;
            end
            if (!hsync && prev_hs) begin
                tests++; if (cyc - hs_rise != HS) begin fails++; $display("FAIL hsync_width got %0d exp %0d", cyc - hs_rise, HS); end
            end
            if (vsync && !prev_vs) begin
                vs_rise = cyc; saw_vs = 1'b1;
            end
            if (!vsync && prev_vs) begin
                tests++; if (cyc - vs_rise != VS * HT) begin fails++; $display("FAIL vsync_width got %0d exp %0d", cyc - vs_rise, VS * HT); end
            end
            if (frame_start) begin
                tests++; if (de !== 1'b1) begin fails++; $display("FAIL fs_de got %0b exp 1", de); end
                if (last_fs >= 0) begin
                    tests++; if (cyc - last_fs != FRAME) begin fails++; $display("FAIL fs_period got %0d exp %0d", cyc - last_fs, FRAME); end
                    tests++; if (de_frame != HA * VA) begin fails++; $display("FAIL de_per_frame got %0d exp %0d", de_frame, HA * VA); end
                end
                last_fs = cyc; de_frame = 0; nfs++;
            end
            if (de && !prev_de) begin
                last_de_rise = cyc; de_line = 1'b1;
                if (saw_vs) begin
                    tests++; if (frame_start !== 1'b1) begin fails++; $display("FAIL fs_after_vsync got %0b exp 1", frame_start); end
                    saw_vs = 1'b0;
                end
            end
            if (!de && prev_de) begin
                tests++; if (de_run != HA) begin fails++; $display("FAIL de_per_line got %0d exp %0d", de_run, HA); end
            end
            if (de) begin
                de_run = prev_de ? de_run + 1 : 1;
                de_frame++;
`ifndef VGA_SYNC_TEST_PATTERN_EN
                tests++; if (rgb_out !== 16'(de_run - 1)) begin fails++; $display("FAIL rgb_column got %0d exp %0d", rgb_out, de_run - 1); end
`endif
            end
            prev_hs = hsync; prev_de = de; prev_vs = vsync;
        end
        tests++; if (nfs < 2) begin fails++; $display("FAIL fs_count got %0d exp >=2", nfs); end
    endtask

    task automatic test_blank_zero;
        force_ff = 1'b1;
        repeat (FRAME + 8) begin
            @(negedge clk);
            if (!de) begin
                tests++; if (rgb_out !== 16'd0) begin fails++; $display("FAIL blank_rgb got %h exp 0000", rgb_out); end
`ifndef VGA_SYNC_TEST_PATTERN_EN
            end else begin
                tests++; if (rgb_out !== 16'hFFFF) begin fails++; $display("FAIL active_ffff got %h exp ffff", rgb_out); end
`endif
            end
        end
        force_ff = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        bit found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge clk);
            if (pix_req && pix_x == 5'd10 && pix_y == 3'd3) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++; $display("FAIL mid_wait got timeout exp pixel (10,3)");
        end else begin
            tests++; if (de !== 1'b1 || rgb_out !== EXP_MID) begin fails++; $display("FAIL pre_reset got de=%0b rgb=%h exp de=1 rgb=%h", de, rgb_out, EXP_MID); end
        end
        rst = 1'b1;
        #1;
        tests++; if (pix_req !== 1'b0 || pix_x !== 5'd0 || pix_y !== 3'd0) begin fails++; $display("FAIL mid_rst_req got req=%0b x=%0d y=%0d exp 0", pix_req, pix_x, pix_y); end
        tests++; if (de !== 1'b0 || rgb_out !== 16'd0) begin fails++; $display("FAIL mid_rst_out got de=%0b rgb=%h exp 0", de, rgb_out); end
        tests++; if (hsync !== 1'b0 || vsync !== 1'b0 || frame_start !== 1'b0) begin fails++; $display("FAIL mid_rst_sync got hs=%0b vs=%0b fs=%0b exp 0", hsync, vsync, frame_start); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= HA + 2; n++) begin
            @(negedge clk);
            if (n == 1) begin
                tests++; if (pix_req !== 1'b1 || pix_x !== 5'd0 || pix_y !== 3'd0) begin fails++; $display("FAIL restart_xy got req=%0b (%0d,%0d) exp req=1 (0,0)", pix_req, pix_x, pix_y); end
            end
            if (n <= 2) begin
                tests++; if (de !== 1'b0 || rgb_out !== 16'd0 || frame_start !== 1'b0) begin fails++; $display("FAIL restart_flush got de=%0b rgb=%h fs=%0b exp 0", de, rgb_out, frame_start); end
            end
            if (n == 3) begin
                tests++; if (de !== 1'b1 || frame_start !== 1'b1 || rgb_out !== EXP_FIRST) begin fails++; $display("FAIL restart_px0 got de=%0b fs=%0b rgb=%h exp 1 1 %h", de, frame_start, rgb_out, EXP_FIRST); end
            end
            if (n == HA + 2) begin
                tests++; if (de !== 1'b1 || rgb_out !== EXP_LAST) begin fails++; $display("FAIL restart_pxlast got de=%0b rgb=%h exp 1 %h", de, rgb_out, EXP_LAST); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_blank_zero();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
